// File: rtl/imem_uart_loader_pkg.sv
// Shared processor definitions: ALU opcodes plus the instruction-memory loader
// state encoding and constants.
package imem_uart_loader_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] END_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_t;

  typedef enum logic [2:0] {
    LD_IDLE, LD_RECV, LD_WRITE, LD_DONE, LD_ERROR
  } ld_state_t;
endpackage

// File: rtl/imem_uart_loader.sv
// Assembles UART bytes into little-endian instruction words and writes them to
// instruction memory from word 0 until the halt sentinel or the memory fills.
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int                 IMEM_DEPTH = 64,
  parameter logic [INSTR_W-1:0] END_WORD   = END_WORD_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic                          imem_wr_en,
  output logic [31:0]                   imem_addr,
  output logic [INSTR_W-1:0]            imem_wr_data,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic [$clog2(IMEM_DEPTH):0]   word_count
);
  localparam int IDX_W = $clog2(IMEM_DEPTH);

  ld_state_t        state, state_nxt;
  logic [1:0]       byte_idx, byte_idx_nxt;
  logic [IDX_W-1:0] word_idx, word_idx_nxt;
  logic [3:0][7:0]  asm_q;
  logic [3:0]       lane_en;
  logic             clr, wc_inc, issue;

  always_comb begin
    state_nxt    = state;
    byte_idx_nxt = byte_idx;
    word_idx_nxt = word_idx;
    lane_en      = '0;
    clr          = 1'b0;
    wc_inc       = 1'b0;
    issue        = 1'b0;
    case (state)
      LD_RECV: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = LD_RECV;
        end else if (rx_valid) begin
          lane_en[byte_idx] = 1'b1;
          byte_idx_nxt      = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            issue     = 1'b1;
            state_nxt = LD_WRITE;
          end
        end
      end
      LD_WRITE: begin
        wc_inc = 1'b1;
        if (start) begin
          clr       = 1'b1;
          state_nxt = LD_RECV;
        end else if (imem_wr_data == END_WORD) begin
          state_nxt = LD_DONE;
        end else if (word_idx == IDX_W'(IMEM_DEPTH - 1)) begin
          state_nxt = LD_ERROR;
        end else begin
          state_nxt    = LD_RECV;
          word_idx_nxt = word_idx + 1'b1;
          // byte landing in the write cycle starts the next word
          if (rx_valid) begin
            lane_en[0]   = 1'b1;
            byte_idx_nxt = 2'd1;
          end
        end
      end
      default: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = LD_RECV;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LD_IDLE;
      byte_idx   <= '0;
      word_idx   <= '0;
      word_count <= '0;
    end else begin
      state      <= state_nxt;
      byte_idx   <= clr ? 2'd0 : byte_idx_nxt;
      word_idx   <= clr ? '0 : word_idx_nxt;
      if (clr)         word_count <= '0;
      else if (wc_inc) word_count <= word_count + 1'b1;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    always_ff @(posedge clk) begin
      if (reset)           asm_q[i] <= '0;
      else if (lane_en[i]) asm_q[i] <= rx_data;
    end
  end

  // Output word is latched as the last byte arrives so it is stable through WRITE
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_addr    <= '0;
      imem_wr_data <= '0;
    end else if (issue) begin
      imem_addr    <= {{(30 - IDX_W){1'b0}}, word_idx, 2'b00};
      imem_wr_data <= {rx_data, asm_q[2], asm_q[1], asm_q[0]};
    end
  end

  assign imem_wr_en = (state == LD_WRITE);
  assign busy       = (state == LD_RECV) || (state == LD_WRITE);
  assign done       = (state == LD_DONE);
  assign overflow   = (state == LD_ERROR);
endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: directed table, corner sequences and random traffic
// checked against a byte-stream model, on a deep and a 4-word instance.
module tb_imem_uart_loader;
  logic       clk = 1'b0;
  logic       reset = 1'b1, start = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  always #5 clk = ~clk;

  logic        a_wr, a_busy, a_done, a_ovf;
  logic [31:0] a_addr, a_data;
  logic [6:0]  a_wc;
  logic        b_wr, b_busy, b_done, b_ovf;
  logic [31:0] b_addr, b_data;
  logic [2:0]  b_wc;

  imem_uart_loader #(.IMEM_DEPTH(64)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .imem_wr_en(a_wr), .imem_addr(a_addr), .imem_wr_data(a_data),
    .busy(a_busy), .done(a_done), .overflow(a_ovf), .word_count(a_wc));

  imem_uart_loader #(.IMEM_DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .imem_wr_en(b_wr), .imem_addr(b_addr), .imem_wr_data(b_data),
    .busy(b_busy), .done(b_done), .overflow(b_ovf), .word_count(b_wc));

  int total = 0, bad = 0;
  bit chk_en = 1'b0;

  // Model: a loader is either active or not; bytes accumulate until four are
  // held, which produces a write the following cycle.
  int          depth [2] = '{64, 4};
  bit          m_act [2], m_wr [2], m_done [2], m_ovf [2];
  int          m_n [2], m_bc [2];
  logic [31:0] m_word [2], m_addr [2], m_data [2];

  task automatic model_step(input int k);
    bit nw;
    if (reset) begin
      m_act[k] = 0; m_wr[k] = 0; m_done[k] = 0; m_ovf[k] = 0;
      m_n[k] = 0; m_bc[k] = 0; m_word[k] = 0; m_addr[k] = 0; m_data[k] = 0;
      chk_en = 1'b1;
      return;
    end
    nw = 0;
    if (start) begin
      m_act[k] = 1; m_bc[k] = 0; m_n[k] = 0; m_done[k] = 0; m_ovf[k] = 0;
    end else begin
      if (m_wr[k]) begin
        m_n[k]++;
        if (m_data[k] == 32'hFFFF_FFFF) begin m_act[k] = 0; m_done[k] = 1; end
        else if (m_n[k] == depth[k]) begin m_act[k] = 0; m_ovf[k] = 1; end
      end
      if (m_act[k] && rx_valid) begin
        m_word[k] = {rx_data, m_word[k][31:8]};
        m_bc[k]++;
        if (m_bc[k] == 4) begin
          nw = 1; m_data[k] = m_word[k]; m_addr[k] = 32'(m_n[k] * 4); m_bc[k] = 0;
        end
      end
    end
    m_wr[k] = nw;
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic mcheck(input int k, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic bsy, input logic dn, input logic ov, input int wc);
    total++;
    if (wr !== m_wr[k] || addr !== m_addr[k] || data !== m_data[k] || bsy !== m_act[k] ||
        dn !== m_done[k] || ov !== m_ovf[k] || wc != m_n[k]) begin
      bad++;
      $display("FAIL model[%0d] t=%0t got wr=%b addr=%h data=%h busy=%b done=%b ovf=%b wc=%0d want wr=%b addr=%h data=%h busy=%b done=%b ovf=%b wc=%0d",
               k, $time, wr, addr, data, bsy, dn, ov, wc,
               m_wr[k], m_addr[k], m_data[k], m_act[k], m_done[k], m_ovf[k], m_n[k]);
    end
  endtask

  logic [63:0] loga [$], logb [$];
  always @(negedge clk) if (chk_en) begin
    mcheck(0, a_wr, a_addr, a_data, a_busy, a_done, a_ovf, 32'(a_wc));
    mcheck(1, b_wr, b_addr, b_data, b_busy, b_done, b_ovf, 32'(b_wc));
    if (a_wr) loga.push_back({a_addr, a_data});
    if (b_wr) logb.push_back({b_addr, b_data});
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic tick(input bit st, input bit v, input logic [7:0] d);
    start = st; rx_valid = v; rx_data = d;
    @(posedge clk); #1;
    start = 0; rx_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 8'h00);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) tick(0, 1, w[8*i +: 8]);
  endtask

  typedef struct {
    bit st; bit v; logic [7:0] d;
    bit wr; logic [31:0] addr; logic [31:0] data; bit busy; bit done; int wc;
  } vec_t;
  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1, 0, 8'h00, 0, 32'h0, 32'h0,         1, 0, 0};
    tbl[1]  = '{0, 1, 8'h13, 0, 32'h0, 32'h0,         1, 0, 0};
    tbl[2]  = '{0, 1, 8'h05, 0, 32'h0, 32'h0,         1, 0, 0};
    tbl[3]  = '{0, 1, 8'hA0, 0, 32'h0, 32'h0,         1, 0, 0};
    tbl[4]  = '{0, 1, 8'h00, 1, 32'h0, 32'h00A0_0513, 1, 0, 0};
    tbl[5]  = '{0, 0, 8'h00, 0, 32'h0, 32'h00A0_0513, 1, 0, 1};
    tbl[6]  = '{0, 1, 8'hFF, 0, 32'h0, 32'h00A0_0513, 1, 0, 1};
    tbl[7]  = '{0, 1, 8'hFF, 0, 32'h0, 32'h00A0_0513, 1, 0, 1};
    tbl[8]  = '{0, 1, 8'hFF, 0, 32'h0, 32'h00A0_0513, 1, 0, 1};
    tbl[9]  = '{0, 1, 8'hFF, 1, 32'h4, 32'hFFFF_FFFF, 1, 0, 1};
    tbl[10] = '{0, 0, 8'h00, 0, 32'h4, 32'hFFFF_FFFF, 0, 1, 2};
    tbl[11] = '{0, 1, 8'h55, 0, 32'h4, 32'hFFFF_FFFF, 0, 1, 2};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {a_wr, a_addr, a_data, a_busy, a_done, a_ovf, a_wc},
        {1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 7'd0});
    reset = 0;

    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].st, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl[%0d]", i), {a_wr, a_addr, a_data, a_busy, a_done, a_wc},
          {tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].busy, tbl[i].done, 7'(tbl[i].wc)});
    end

    // back-to-back bytes across a word boundary
    tick(1, 0, 8'h00); loga.delete();
    for (int i = 0; i < 8; i++) tick(0, 1, 8'(8'h11 * (i + 1)));
    idle(2);
    chk("b2b_count", 128'(loga.size()), 128'd2);
    if (loga.size() == 2) begin
      chk("b2b_w0", 128'(loga[0]), {64'h0, 32'h0, 32'h4433_2211});
      chk("b2b_w1", 128'(loga[1]), {64'h0, 32'h4, 32'h8877_6655});
    end
    chk("b2b_wc", 128'(a_wc), 128'd2);

    // two words then sentinel
    tick(1, 0, 8'h00); loga.delete();
    send_word(32'h1234_5678); send_word(32'h0BAD_F00D); send_word(32'hFFFF_FFFF);
    chk("sent_wr", {a_wr, a_addr, a_done}, {1'b1, 32'h8, 1'b0});
    idle(1);
    chk("sent_done", {a_done, a_busy, a_wc}, {1'b1, 1'b0, 7'd3});
    chk("sent_count", 128'(loga.size()), 128'd3);
    if (loga.size() == 3) chk("sent_w2", 128'(loga[2]), {64'h0, 32'h8, 32'hFFFF_FFFF});

    // abort partway through a word
    tick(1, 0, 8'h00); tick(0, 1, 8'h01); tick(0, 1, 8'h02);
    tick(1, 1, 8'h99); loga.delete();
    send_word(32'hDDCC_BBAA); idle(2);
    chk("abort_count", 128'(loga.size()), 128'd1);
    if (loga.size() == 1) chk("abort_w", 128'(loga[0]), {64'h0, 32'h0, 32'hDDCC_BBAA});

    // fill the 4-word instance without a sentinel
    tick(1, 0, 8'h00); logb.delete();
    for (int i = 0; i < 4; i++) send_word(32'h0100_0000 + i);
    idle(2);
    chk("ovf_state", {b_ovf, b_busy, b_done, b_wc}, {1'b1, 1'b0, 1'b0, 3'd4});
    chk("ovf_count", 128'(logb.size()), 128'd4);
    if (logb.size() == 4) chk("ovf_last", 128'(logb[3]), {64'h0, 32'hC, 32'h0100_0003});
    send_word(32'h5555_5555); send_word(32'h6666_6666); idle(2);
    chk("ovf_quiet", 128'(logb.size()), 128'd4);

    // reset during RECV
    tick(1, 0, 8'h00); tick(0, 1, 8'h10); tick(0, 1, 8'h20);
    reset = 1; tick(0, 1, 8'h30); reset = 0;
    chk("rst_mid", {a_wr, a_addr, a_data, a_busy, a_done, a_ovf, a_wc},
        {1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 7'd0});
    loga.delete();
    send_word(32'h7777_7777); idle(2);
    chk("rst_ignore", {32'(loga.size()), a_busy}, {32'd0, 1'b0});

    // random traffic against the model
    repeat (3000) begin
      reset = ($urandom_range(0, 299) == 0);
      tick($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) ? 8'hFF : 8'($urandom));
      reset = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_uart_loader.md
# imem_uart_loader

Writer side of the processor's instruction memory. Receives a program as a byte stream from the UART receiver, assembles little-endian 32-bit instruction words and writes them into instruction memory at consecutive word addresses starting at 0. Loading stops when a halt sentinel word is received or the memory fills. `busy`/`done` let the top-level control FSM hold the pipeline in reset until loading completes.

## Interface
Parameters:
- `IMEM_DEPTH`, 64: instruction memory depth in 32-bit words; power of two, ≥ 2.
- `END_WORD`, 32'hFFFF_FFFF: halt sentinel. It is written to memory, then loading ends.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse that begins or restarts a load.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `imem_wr_en` out 1: instruction memory write strobe.
- `imem_addr` out 32: byte address; word index × 4.
- `imem_wr_data` out 32: assembled instruction word.
- `busy` out 1: load in progress (RECV or WRITE).
- `done` out 1: sentinel written; sticky.
- `overflow` out 1: memory filled without a sentinel; sticky.
- `word_count` out $clog2(IMEM_DEPTH)+1: words written in the current load.

## Operation
- States: IDLE, RECV, WRITE, DONE, ERROR. Reset state is IDLE.
- IDLE: `rx_valid` is ignored. `start` → RECV, clearing the byte index, word index, `word_count`, `done` and `overflow`.
- RECV: each `rx_valid` stores `rx_data` into byte lane `byte_idx` (first byte → [7:0], fourth → [31:24]) and increments the 2-bit `byte_idx`. The byte that completes lane 3 → WRITE.
- WRITE: lasts exactly one cycle.
  - `imem_wr_en`=1, `imem_wr_data`=assembled word, `imem_addr`={word_idx,2'b00}.
  - `word_count` increments at the end of the cycle.
  - Next state:
    - word == `END_WORD` → DONE;
    - else word_idx == IMEM_DEPTH-1 → ERROR;
    - else RECV with word_idx+1.
- An `rx_valid` arriving during WRITE is captured into lane 0 of the next word, so no byte is lost. The captured byte is discarded if the next state is DONE or ERROR.
- DONE: `done`=1. ERROR: `overflow`=1. In both, `rx_valid` is ignored, and `start` restarts exactly as from IDLE.
- `start` in RECV or WRITE aborts the load and restarts:
  - counters clear and the partial word is dropped;
  - a write already in the WRITE cycle completes that cycle;
  - `rx_valid` coincident with `start` is ignored.
- Memory contents beyond the last written word are not modified.
- `reset` mid-load returns to IDLE. Memory is untouched.

## Timing
- Reset values: `imem_wr_en`=0, `imem_addr`=0, `imem_wr_data`=0, `busy`=0, `done`=0, `overflow`=0, `word_count`=0.
- `start` in cycle N → `busy`=1 from N+1.
- Fourth byte's `rx_valid` in cycle N → `imem_wr_en`=1 in cycle N+1 only.
- `word_count` reflects that write from N+2.
- Sentinel write in cycle M → `done`=1 and `busy`=0 from M+1.
- Last-slot non-sentinel write in cycle M → `overflow`=1 and `busy`=0 from M+1.
- `imem_addr` and `imem_wr_data` are registered and hold their last values outside WRITE. Memory ignores them when `imem_wr_en`=0.
- Sustained throughput: one byte per cycle. Minimum 4 cycles per word.

## Structure
- Shared package holds the loader state encoding, the default `END_WORD` constant and the instruction width (32), alongside the existing ALU opcode defines.
- Single module, no sub-modules. The byte assembler is a 32-bit register with per-lane enables decoded from `byte_idx`.

## Test plan
- Reset then `start`; send bytes 13,05,A0,00 → one write: addr 0x0, data 0x00A0_0513; `word_count`=1.
- Two words, then sentinel bytes FF×4 → writes at 0x0, 0x4, 0x8 (data FFFF_FFFF); `done`=1 the cycle after the third write; `busy`=0.
- IMEM_DEPTH=4; send 4 non-sentinel words → writes 0x0–0xC, then `overflow`=1; further bytes produce no writes.
- `rx_valid` on consecutive cycles across a word boundary (8 back-to-back bytes) → two correct words; the byte arriving in the WRITE cycle lands in lane 0 of word 2.
- After 2 bytes of a word, pulse `start`, then send 4 bytes AA,BB,CC,DD → single write addr 0x0, data 0xDDCC_BBAA.
- Assert `reset` during RECV → all outputs at reset values next cycle; subsequent `rx_valid` ignored until `start`.
